mxint8_dot_product_accum: RTL and testbench
===========================================

# mxint8_dot_product_accum

Streaming, parametrised successor to the combinational MXINT8 block dot product. It accepts a sequence of MXINT8 block pairs over a valid/ready handshake and accumulates their dot products in a wide block-floating accumulator. When the last block of a vector arrives, it emits one rounded float32 result with overflow, underflow and NaN flags. It sits between the MX operand buffers and the float32 result path of the MX ALU.

## Interface
- BLOCK_SIZE, 32, elements per MX block
- ELEM_WIDTH, 8, MXINT8 element width; two's complement, value = int × 2^-6
- SCALE_WIDTH, 8, E8M0 shared scale width; bias 127; 0xFF = NaN
- MAX_BLOCKS, 16, maximum blocks per vector
- GUARD_BITS, 8, fractional guard bits kept below each block's LSB during alignment
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- i_valid  input  1  block pair valid
- o_ready  output  1  block pair accepted when i_valid & o_ready
- i_last  input  1  final block of the vector
- i_scale_a, i_scale_b  input  SCALE_WIDTH  shared scales
- i_mxint8_elements_a, i_mxint8_elements_b  input  [BLOCK_SIZE][ELEM_WIDTH]  elements
- o_valid  output  1  result valid; held until accepted
- i_ready  input  1  result consumed when o_valid & i_ready
- o_float32  output  32  IEEE-754 binary32 result
- o_overflow, o_underflow, o_is_NaN  output  1 each  result flags, qualified by o_valid
- o_block_count  output  clog2(MAX_BLOCKS)+1  number of blocks in the emitted result

## Operation
- Stage S1, registered on accept:
  - S = Σ a_i·b_i, signed, 2·ELEM_WIDTH+clog2(BLOCK_SIZE) bits.
  - E = scale_a + scale_b, unsigned, SCALE_WIDTH+1 bits.
  - nan = (scale_a==0xFF) | (scale_b==0xFF).
- Block value = S·2^(E−254−12).
- Accumulator: signed mantissa M, ACC_WIDTH = S width + clog2(MAX_BLOCKS) + GUARD_BITS + 1; exponent register Ea; sticky NaN bit.
- First block of a vector: M = S<<GUARD_BITS, Ea = E.
- Later blocks, with S' = S<<GUARD_BITS:
  - E ≥ Ea: M = (M >>> (E−Ea)) + S', Ea = E.
  - E < Ea: M = M + (S' >>> (Ea−E)).
  - Shifts are arithmetic and truncating (floor). Any shift ≥ ACC_WIDTH yields the sign fill.
- Finalisation, applied to M·2^(Ea−266−GUARD_BITS):
  - NaN sticky set: 0x7FC00000, o_is_NaN=1, no other flag.
  - M==0: 0x00000000.
  - Otherwise: leading-one detect on |M|, round to 24 significant bits with round-to-nearest-even, renormalise on mantissa carry.
  - Biased exponent > 254: ±inf (0x7F800000 / 0xFF800000), o_overflow=1.
  - Biased exponent < 1: signed zero, o_underflow=1. No subnormals are produced.
- FSM states:
  - ACCUM: o_ready=1. Accepting with i_last=1 → DRAIN.
  - DRAIN: o_ready=0; the last block passes S1 into M → FINAL.
  - FINAL: o_ready=0; normalise and round into output registers; o_valid=1 → OUT.
  - OUT: hold outputs. On i_ready → ACCUM, clear accumulator, first-block flag set.
- Accepting the MAX_BLOCKS-th block without i_last forces termination exactly as if i_last=1.
- o_block_count counts accepted blocks of the current vector and is registered with the result.

## Timing
- Reset values: o_ready=1, o_valid=0, o_float32=0, all flags 0, o_block_count=0, state ACCUM, M=0, Ea=0, NaN sticky 0.
- Throughput: one block per cycle in ACCUM; back-to-back accepts have no bubbles.
- Latency: last block accepted at edge t → S1 at t+1 → M at t+2 → o_valid high after edge t+3.
- i_valid while o_ready=0 is ignored; the source must hold the data.
- o_valid, o_float32 and the flags are stable while o_valid & !i_ready.
- Result accepted at edge r: o_ready=1 after r; the next vector may be accepted at r+1.
- rst asserted mid-vector or in OUT: immediate return to reset values; partial sums are discarded and no result is emitted.
- Single-block vector (i_last on first accept) is legal, with the same latency.

## Test plan
- Scales 127/127, all elements 0x40, i_last on first block → 0x42000000 (32.0), block_count 1, flags 0, o_valid 3 cycles after accept.
- Block 1 scales 128/127, block 2 scales 127/127, all elements 0x40, back-to-back → 0x42C00000 (96.0), block_count 2.
- scale_a=0xFF in block 2 of 3 → 0x7FC00000, o_is_NaN=1. Scales 254/254, elements 0x40 → 0x7F800000, o_overflow=1. Scales 1/1 → 0x00000000, o_underflow=1.
- 16 blocks at 127/127 with elements 0x40 and i_last never asserted → forced result 0x44000000 (512.0), block_count 16, o_ready low from accept 16 until result taken.
- Hold i_ready=0 for 5 cycles → outputs stable and o_ready=0 throughout. Assert rst after 3 of 5 blocks → o_valid stays 0; next vector 127/127, 0x40 → 0x42000000.

Source files
------------

// File: rtl/mxint8_dot_product_accum.sv
// Streaming MXINT8 block dot-product accumulator.
// Accepts MXINT8 block pairs over valid/ready, folds their dot products into a
// block-floating accumulator and emits one rounded float32 result per vector.
module mxint8_dot_product_accum #(
    parameter int BLOCK_SIZE  = 32,
    parameter int ELEM_WIDTH  = 8,
    parameter int SCALE_WIDTH = 8,
    parameter int MAX_BLOCKS  = 16,
    parameter int GUARD_BITS  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_valid,
    output logic                                  o_ready,
    input  logic                                  i_last,
    input  logic [SCALE_WIDTH-1:0]                i_scale_a,
    input  logic [SCALE_WIDTH-1:0]                i_scale_b,
    input  logic [BLOCK_SIZE-1:0][ELEM_WIDTH-1:0] i_mxint8_elements_a,
    input  logic [BLOCK_SIZE-1:0][ELEM_WIDTH-1:0] i_mxint8_elements_b,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic [31:0]                           o_float32,
    output logic                                  o_overflow,
    output logic                                  o_underflow,
    output logic                                  o_is_NaN,
    output logic [$clog2(MAX_BLOCKS):0]           o_block_count
);
    localparam int SUM_W      = 2 * ELEM_WIDTH + $clog2(BLOCK_SIZE);
    localparam int EXP_W      = SCALE_WIDTH + 1;
    localparam int ACC_W      = SUM_W + $clog2(MAX_BLOCKS) + GUARD_BITS + 1;
    localparam int CNT_W      = $clog2(MAX_BLOCKS) + 1;
    localparam int SCALE_BIAS = (1 << (SCALE_WIDTH - 1)) - 1;
    localparam int FRAC_BITS  = ELEM_WIDTH - 2;
    // Converts (leading-one index + Ea) into a biased binary32 exponent.
    localparam int EXP_OFFSET = 2 * SCALE_BIAS + 2 * FRAC_BITS + GUARD_BITS - 127;

    typedef enum logic [1:0] {ST_ACCUM, ST_DRAIN, ST_FINAL, ST_OUT} state_t;

    state_t stateQ, stateD;
    logic   accept, lastBlock, clearAcc;

    logic [BLOCK_SIZE-1:0][ELEM_WIDTH-1:0] capA_q, capB_q;
    logic [SCALE_WIDTH-1:0]                capScaleA_q, capScaleB_q;
    logic                                  capValid_q;

    logic signed [SUM_W-1:0] sumD, s1Sum_q;
    logic [EXP_W-1:0]        expD, s1Exp_q;
    logic                    nanD, s1Nan_q, s1Valid_q;

    logic signed [ACC_W-1:0] acc_q, acc_d, sAligned;
    logic [EXP_W-1:0]        ea_q, ea_d;
    logic                    nanSticky_q, nanSticky_d;
    logic                    first_q, first_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [ACC_W-1:0] mag, norm;
    logic [24:0]      mant;
    logic [22:0]      frac;
    logic             sgn, rndUp;
    int               lead, biasedExp;
    logic [31:0]      resFloat;
    logic             resOvf, resUnf, resNan;

    logic [31:0]      float_q;
    logic             ovf_q, unf_q, nanOut_q;
    logic [CNT_W-1:0] outCnt_q;

    // Arithmetic right shift that saturates to the sign fill for oversized shifts.
    function automatic logic signed [ACC_W-1:0] asr(input logic signed [ACC_W-1:0] x,
                                                     input logic [EXP_W-1:0] amt);
        logic signed [ACC_W-1:0] r;
        if (int'(amt) >= ACC_W) r = {ACC_W{x[ACC_W-1]}};
        else                    r = x >>> amt;
        return r;
    endfunction

    // Handshake, vector termination and state sequencing.
    always_comb begin
        stateD    = stateQ;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        accept    = 1'b0;
        clearAcc  = 1'b0;
        lastBlock = i_last | (cnt_q == CNT_W'(MAX_BLOCKS - 1));
        case (stateQ)
            ST_ACCUM: begin
                o_ready = 1'b1;
                accept  = i_valid;
                if (i_valid && lastBlock) stateD = ST_DRAIN;
            end
            ST_DRAIN: if (!capValid_q) stateD = ST_FINAL;
            ST_FINAL: stateD = ST_OUT;
            ST_OUT: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    clearAcc = 1'b1;
                    stateD   = ST_ACCUM;
                end
            end
            default: stateD = ST_ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stateQ <= ST_ACCUM;
        else     stateQ <= stateD;
    end

    // Capture the accepted block pair so the adder tree starts from registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capA_q      <= '0;
            capB_q      <= '0;
            capScaleA_q <= '0;
            capScaleB_q <= '0;
            capValid_q  <= 1'b0;
        end else begin
            capValid_q <= accept;
            if (accept) begin
                capA_q      <= i_mxint8_elements_a;
                capB_q      <= i_mxint8_elements_b;
                capScaleA_q <= i_scale_a;
                capScaleB_q <= i_scale_b;
            end
        end
    end

    // Block dot product, combined exponent and NaN detection.
    always_comb begin
        sumD = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            sumD = sumD + SUM_W'($signed(capA_q[i]) * $signed(capB_q[i]));
        end
        expD = EXP_W'(capScaleA_q) + EXP_W'(capScaleB_q);
        nanD = (&capScaleA_q) | (&capScaleB_q);
    end

    // S1 pipeline register holding one block's sum, exponent and NaN bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Sum_q   <= '0;
            s1Exp_q   <= '0;
            s1Nan_q   <= 1'b0;
            s1Valid_q <= 1'b0;
        end else begin
            s1Valid_q <= capValid_q;
            if (capValid_q) begin
                s1Sum_q <= sumD;
                s1Exp_q <= expD;
                s1Nan_q <= nanD;
            end
        end
    end

    // Align the incoming block against the running mantissa and add.
    always_comb begin
        acc_d       = acc_q;
        ea_d        = ea_q;
        nanSticky_d = nanSticky_q;
        first_d     = first_q;
        sAligned    = ACC_W'(s1Sum_q) << GUARD_BITS;
        if (clearAcc) begin
            acc_d       = '0;
            ea_d        = '0;
            nanSticky_d = 1'b0;
            first_d     = 1'b1;
        end else if (s1Valid_q) begin
            nanSticky_d = nanSticky_q | s1Nan_q;
            first_d     = 1'b0;
            if (first_q) begin
                acc_d = sAligned;
                ea_d  = s1Exp_q;
            end else if (s1Exp_q >= ea_q) begin
                acc_d = asr(acc_q, s1Exp_q - ea_q) + sAligned;
                ea_d  = s1Exp_q;
            end else begin
                acc_d = acc_q + asr(sAligned, ea_q - s1Exp_q);
            end
        end
    end

    // Accumulator, exponent, NaN sticky and first-block flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            ea_q        <= '0;
            nanSticky_q <= 1'b0;
            first_q     <= 1'b1;
        end else begin
            acc_q       <= acc_d;
            ea_q        <= ea_d;
            nanSticky_q <= nanSticky_d;
            first_q     <= first_d;
        end
    end

    // Accepted-block counter for the vector in flight.
    always_comb begin
        cnt_d = cnt_q;
        if (clearAcc)    cnt_d = '0;
        else if (accept) cnt_d = cnt_q + CNT_W'(1);
    end

    // Block counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Normalise |M|, round to nearest even at 24 bits and classify the result.
    always_comb begin
        resFloat = '0;
        resOvf   = 1'b0;
        resUnf   = 1'b0;
        resNan   = 1'b0;
        sgn      = acc_q[ACC_W-1];
        mag      = sgn ? -acc_q : acc_q;
        lead     = 0;
        for (int k = 0; k < ACC_W; k++) begin
            if (mag[k]) lead = k;
        end
        norm      = mag << (ACC_W - 1 - lead);
        rndUp     = norm[ACC_W-25] & (norm[ACC_W-24] | (|norm[ACC_W-26:0]));
        mant      = {1'b0, norm[ACC_W-1 -: 24]} + {24'd0, rndUp};
        biasedExp = lead + int'(ea_q) - EXP_OFFSET + (mant[24] ? 1 : 0);
        frac      = mant[24] ? mant[23:1] : mant[22:0];
        if (nanSticky_q) begin
            resFloat = 32'h7FC0_0000;
            resNan   = 1'b1;
        end else if (acc_q == '0) begin
            resFloat = 32'h0000_0000;
        end else if (biasedExp > 254) begin
            resFloat = {sgn, 8'hFF, 23'd0};
            resOvf   = 1'b1;
        end else if (biasedExp < 1) begin
            resFloat = {sgn, 31'd0};
            resUnf   = 1'b1;
        end else begin
            resFloat = {sgn, biasedExp[7:0], frac};
        end
    end

    // Result registers, loaded once per vector and held until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            float_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            nanOut_q <= 1'b0;
            outCnt_q <= '0;
        end else if (stateQ == ST_FINAL) begin
            float_q  <= resFloat;
            ovf_q    <= resOvf;
            unf_q    <= resUnf;
            nanOut_q <= resNan;
            outCnt_q <= cnt_q;
        end
    end

    assign o_float32     = float_q;
    assign o_overflow    = ovf_q;
    assign o_underflow   = unf_q;
    assign o_is_NaN      = nanOut_q;
    assign o_block_count = outCnt_q;
endmodule

// File: tb/tb_mxint8_dot_product_accum.sv
// Self-checking bench for mxint8_dot_product_accum using a result scoreboard.
module tb_mxint8_dot_product_accum;
    typedef logic [31:0][7:0] elemVec_t;
    typedef struct {
        logic [31:0] f;
        logic [2:0]  flags;   // {overflow, underflow, NaN}
        logic [4:0]  cnt;
    } result_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_last, i_ready;
    logic [7:0]  i_scale_a, i_scale_b;
    elemVec_t    i_a, i_b;
    logic        o_ready, o_valid, o_overflow, o_underflow, o_is_NaN;
    logic [31:0] o_float32;
    logic [4:0]  o_block_count;

    result_t     sbQueue[$];
    result_t     expItem;
    logic [39:0] got, want;
    int          nChecks = 0;
    int          nFails  = 0;

    always #5 clk = ~clk;

    mxint8_dot_product_accum dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_valid             (i_valid),
        .o_ready             (o_ready),
        .i_last              (i_last),
        .i_scale_a           (i_scale_a),
        .i_scale_b           (i_scale_b),
        .i_mxint8_elements_a (i_a),
        .i_mxint8_elements_b (i_b),
        .o_valid             (o_valid),
        .i_ready             (i_ready),
        .o_float32           (o_float32),
        .o_overflow          (o_overflow),
        .o_underflow         (o_underflow),
        .o_is_NaN            (o_is_NaN),
        .o_block_count       (o_block_count)
    );

    function automatic elemVec_t fillVec(input logic [7:0] v);
        elemVec_t e;
        for (int i = 0; i < 32; i++) e[i] = v;
        return e;
    endfunction

    function automatic result_t mkRes(input logic [31:0] f, input logic [2:0] fl, input int c);
        result_t r;
        r.f = f; r.flags = fl; r.cnt = 5'(c);
        return r;
    endfunction

    // Exact integer dot product of one block.
    function automatic longint blockSum(input elemVec_t a, input elemVec_t b);
        longint s = 0;
        for (int i = 0; i < 32; i++) s += longint'($signed(a[i])) * longint'($signed(b[i]));
        return s;
    endfunction

    // Value t * 2^expUnit rounded to binary32 (normal range only).
    function automatic logic [31:0] toFloat(input longint t, input int expUnit);
        longint mag, q, rem, half;
        int p, be, sh;
        logic s;
        if (t == 0) return 32'h0;
        s   = (t < 0);
        mag = s ? -t : t;
        p   = 0;
        while ((mag >> (p + 1)) != 0) p++;
        be = p + expUnit + 127;
        if (p > 23) begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                be++;
            end
        end else begin
            q = mag << (23 - p);
        end
        return {s, be[7:0], q[22:0]};
    endfunction

    // Drive one block at a negedge, wait (bounded) for o_ready, let it be accepted.
    task automatic applyStimulus(input logic [7:0] sa, input logic [7:0] sb,
                                 input elemVec_t ea, input elemVec_t eb,
                                 input logic last, output int stalls);
        stalls    = 0;
        i_valid   = 1'b1;
        i_last    = last;
        i_scale_a = sa;
        i_scale_b = sb;
        i_a       = ea;
        i_b       = eb;
        while (!o_ready && stalls < 50) begin
            @(negedge clk);
            stalls++;
        end
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    // Wait (bounded) until o_valid is seen at a negedge.
    task automatic waitResult(output bit ok, output int cycles);
        cycles = 0;
        while (!o_valid && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
        ok = o_valid;
    endtask

    task automatic releaseResult();
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nChecks++; if (o_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_ready got=%b want=1", o_ready); end
        nChecks++; if (o_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid got=%b want=0", o_valid); end
        nChecks++; if (o_float32 !== 32'h0) begin nFails++; $display("[TB] FAIL reset_float got=%h want=0", o_float32); end
        nChecks++;
        if ({o_overflow, o_underflow, o_is_NaN} !== 3'b000) begin
            nFails++; $display("[TB] FAIL reset_flags got=%b want=000", {o_overflow, o_underflow, o_is_NaN});
        end
        nChecks++; if (o_block_count !== 5'd0) begin nFails++; $display("[TB] FAIL reset_count got=%0d want=0", o_block_count); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_block();
        int st, lat;
        bit ok;
        sbQueue.push_back(mkRes(32'h4200_0000, 3'b000, 1));
        applyStimulus(8'd127, 8'd127, fillVec(8'h40), fillVec(8'h40), 1'b1, st);
        waitResult(ok, lat);
        nChecks++; if (lat != 3) begin nFails++; $display("[TB] FAIL single_latency got=%0d want=3", lat); end
        expItem = sbQueue.pop_front();
        got  = {o_float32, o_overflow, o_underflow, o_is_NaN, o_block_count};
        want = {expItem.f, expItem.flags, expItem.cnt};
        nChecks++; if (!ok || got !== want) begin nFails++; $display("[TB] FAIL single_result got=%h want=%h", got, want); end
        releaseResult();
        nChecks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            nFails++; $display("[TB] FAIL single_after_release got ready=%b valid=%b want ready=1 valid=0", o_ready, o_valid);
        end
    endtask

    task automatic test_back_to_back();
        int st, cyc;
        bit ok;
        sbQueue.push_back(mkRes(32'h42C0_0000, 3'b000, 2));
        applyStimulus(8'd128, 8'd127, fillVec(8'h40), fillVec(8'h40), 1'b0, st);
        applyStimulus(8'd127, 8'd127, fillVec(8'h40), fillVec(8'h40), 1'b1, st);
        nChecks++; if (st != 0) begin nFails++; $display("[TB] FAIL b2b_stall got=%0d want=0", st); end
        waitResult(ok, cyc);
        expItem = sbQueue.pop_front();
        got  = {o_float32, o_overflow, o_underflow, o_is_NaN, o_block_count};
        want = {expItem.f, expItem.flags, expItem.cnt};
        nChecks++; if (!ok || got !== want) begin nFails++; $display("[TB] FAIL b2b_result got=%h want=%h", got, want); end
        releaseResult();
    endtask

    task automatic test_flags();
        int st, cyc;
        bit ok;
        // NaN scale in the middle block of three.
        sbQueue.push_back(mkRes(32'h7FC0_0000, 3'b001, 3));
        applyStimulus(8'd127, 8'd127, fillVec(8'h40), fillVec(8'h40), 1'b0, st);
        applyStimulus(8'hFF,  8'd127, fillVec(8'h40), fillVec(8'h40), 1'b0, st);
        applyStimulus(8'd127, 8'd127, fillVec(8'h40), fillVec(8'h40), 1'b1, st);
        waitResult(ok, cyc);
        expItem = sbQueue.pop_front();
        got  = {o_float32, o_overflow, o_underflow, o_is_NaN, o_block_count};
        want = {expItem.f, expItem.flags, expItem.cnt};
        nChecks++; if (!ok || got !== want) begin nFails++; $display("[TB] FAIL nan_result got=%h want=%h", got, want); end
        releaseResult();
        // Overflow to +inf.
        sbQueue.push_back(mkRes(32'h7F80_0000, 3'b100, 1));
        applyStimulus(8'd254, 8'd254, fillVec(8'h40), fillVec(8'h40), 1'b1, st);
        waitResult(ok, cyc);
        expItem = sbQueue.pop_front();
        got  = {o_float32, o_overflow, o_underflow, o_is_NaN, o_block_count};
        want = {expItem.f, expItem.flags, expItem.cnt};
        nChecks++; if (!ok || got !== want) begin nFails++; $display("[TB] FAIL ovf_result got=%h want=%h", got, want); end
        releaseResult();
        // Underflow to zero.
        sbQueue.push_back(mkRes(32'h0000_0000, 3'b010, 1));
        applyStimulus(8'd1, 8'd1, fillVec(8'h40), fillVec(8'h40), 1'b1, st);
        waitResult(ok, cyc);
        expItem = sbQueue.pop_front();
        got  = {o_float32, o_overflow, o_underflow, o_is_NaN, o_block_count};
        want = {expItem.f, expItem.flags, expItem.cnt};
        nChecks++; if (!ok || got !== want) begin nFails++; $display("[TB] FAIL unf_result got=%h want=%h", got, want); end
        releaseResult();
        // Negative result: 32 * 64 * -64 * 2^-12 = -32.
        sbQueue.push_back(mkRes(32'hC200_0000, 3'b000, 1));
        applyStimulus(8'd127, 8'd127, fillVec(8'h40), fillVec(8'hC0), 1'b1, st);
        waitResult(ok, cyc);
        expItem = sbQueue.pop_front();
        got  = {o_float32, o_overflow, o_underflow, o_is_NaN, o_block_count};
        want = {expItem.f, expItem.flags, expItem.cnt};
        nChecks++; if (!ok || got !== want) begin nFails++; $display("[TB] FAIL neg_result got=%h want=%h", got, want); end
        releaseResult();
    endtask

    task automatic test_forced_last();
        int st, cyc;
        int readyHigh;
        bit ok;
        sbQueue.push_back(mkRes(32'h4400_0000, 3'b000, 16));
        for (int k = 0; k < 16; k++) begin
            applyStimulus(8'd127, 8'd127, fillVec(8'h40), fillVec(8'h40), 1'b0, st);
        end
        nChecks++; if (st != 0) begin nFails++; $display("[TB] FAIL forced_stall got=%0d want=0", st); end
        readyHigh = 0;
        cyc = 0;
        while (!o_valid && cyc < 60) begin
            if (o_ready) readyHigh++;
            @(negedge clk);
            cyc++;
        end
        ok = o_valid;
        for (int k = 0; k < 2; k++) begin
            if (o_ready) readyHigh++;
            @(negedge clk);
        end
        nChecks++; if (readyHigh != 0) begin nFails++; $display("[TB] FAIL forced_ready_low got=%0d cycles high want=0", readyHigh); end
        expItem = sbQueue.pop_front();
        got  = {o_float32, o_overflow, o_underflow, o_is_NaN, o_block_count};
        want = {expItem.f, expItem.flags, expItem.cnt};
        nChecks++; if (!ok || got !== want) begin nFails++; $display("[TB] FAIL forced_result got=%h want=%h", got, want); end
        releaseResult();
        nChecks++; if (o_ready !== 1'b1) begin nFails++; $display("[TB] FAIL forced_ready_after got=%b want=1", o_ready); end
    endtask

    task automatic test_hold();
        int st, cyc, spurious;
        bit ok;
        sbQueue.push_back(mkRes(32'h4200_0000, 3'b000, 1));
        applyStimulus(8'd127, 8'd127, fillVec(8'h40), fillVec(8'h40), 1'b1, st);
        waitResult(ok, cyc);
        expItem = sbQueue.pop_front();
        want = {expItem.f, expItem.flags, expItem.cnt};
        for (int c = 0; c < 5; c++) begin
            got = {o_float32, o_overflow, o_underflow, o_is_NaN, o_block_count};
            nChecks++;
            if (!o_valid || o_ready || got !== want) begin
                nFails++;
                $display("[TB] FAIL hold_cycle%0d got valid=%b ready=%b res=%h want valid=1 ready=0 res=%h",
                         c, o_valid, o_ready, got, want);
            end
            if (c == 1) begin
                // Offered while not ready: must be ignored.
                i_valid   = 1'b1;
                i_last    = 1'b1;
                i_scale_a = 8'hFF;
                i_scale_b = 8'hFF;
            end
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        releaseResult();
        spurious = 0;
        for (int c = 0; c < 6; c++) begin
            if (o_valid) spurious++;
            @(negedge clk);
        end
        nChecks++; if (spurious != 0) begin nFails++; $display("[TB] FAIL hold_ignored_input got=%0d valid cycles want=0", spurious); end
    endtask

    task automatic test_reset_mid();
        int st, cyc, spurious;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(8'd130, 8'd127, fillVec(8'h40), fillVec(8'h40), 1'b0, st);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        for (int c = 0; c < 8; c++) begin
            if (o_valid || !o_ready) spurious++;
            @(negedge clk);
        end
        nChecks++; if (spurious != 0) begin nFails++; $display("[TB] FAIL rstmid_idle got=%0d bad cycles want=0", spurious); end
        sbQueue.push_back(mkRes(32'h4200_0000, 3'b000, 1));
        applyStimulus(8'd127, 8'd127, fillVec(8'h40), fillVec(8'h40), 1'b1, st);
        waitResult(ok, cyc);
        expItem = sbQueue.pop_front();
        got  = {o_float32, o_overflow, o_underflow, o_is_NaN, o_block_count};
        want = {expItem.f, expItem.flags, expItem.cnt};
        nChecks++; if (!ok || got !== want) begin nFails++; $display("[TB] FAIL rstmid_result got=%h want=%h", got, want); end
        releaseResult();
    endtask

    task automatic test_random();
        logic [7:0] sa[5], sb[5];
        elemVec_t   ea[5], eb[5];
        int         nb, base, eMin, st, cyc;
        longint     total;
        bit         ok;
        for (int v = 0; v < 8; v++) begin
            nb   = $urandom_range(1, 5);
            base = $urandom_range(110, 140);
            eMin = 1000;
            for (int k = 0; k < nb; k++) begin
                sa[k] = 8'(base + $urandom_range(0, 4));
                sb[k] = 8'(base + $urandom_range(0, 4));
                for (int i = 0; i < 32; i++) begin
                    ea[k][i] = 8'($urandom);
                    eb[k][i] = 8'($urandom);
                end
                if (int'(sa[k]) + int'(sb[k]) < eMin) eMin = int'(sa[k]) + int'(sb[k]);
            end
            total = 0;
            for (int k = 0; k < nb; k++) begin
                total += blockSum(ea[k], eb[k]) <<< (int'(sa[k]) + int'(sb[k]) - eMin);
            end
            sbQueue.push_back(mkRes(toFloat(total, eMin - 266), 3'b000, nb));
            for (int k = 0; k < nb; k++) begin
                applyStimulus(sa[k], sb[k], ea[k], eb[k], (k == nb - 1), st);
            end
            waitResult(ok, cyc);
            expItem = sbQueue.pop_front();
            got  = {o_float32, o_overflow, o_underflow, o_is_NaN, o_block_count};
            want = {expItem.f, expItem.flags, expItem.cnt};
            nChecks++; if (!ok || got !== want) begin nFails++; $display("[TB] FAIL random_vec%0d got=%h want=%h", v, got, want); end
            releaseResult();
        end
    endtask

    initial begin
        rst       = 1'b1;
        i_valid   = 1'b0;
        i_last    = 1'b0;
        i_ready   = 1'b0;
        i_scale_a = '0;
        i_scale_b = '0;
        i_a       = '0;
        i_b       = '0;
        test_reset();
        test_single_block();
        test_back_to_back();
        test_flags();
        test_forced_last();
        test_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end
endmodule
